// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag control for fifo_param.
module fifo_ptr_ctrl import fifo_pkg::*; #(
  parameter int unsigned Depth   = 16,
  parameter int unsigned AfLevel = 14,
  parameter int unsigned AeLevel = 2,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned CntW   = fifo_cnt_w(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             clear_err_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic             wr_acc_o,
  output logic [AddrW-1:0] wr_idx_o,
  output logic [AddrW-1:0] rd_idx_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [CntW-1:0] AfLvl = CntW'(AfLevel);
  localparam logic [CntW-1:0] AeLvl = CntW'(AeLevel);

  logic [AddrW:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            full, empty, wr_acc, rd_acc, ovf_set, udf_set;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    rd_acc  = !flush_i && rd_en_i && !empty;
    wr_acc  = !flush_i && wr_en_i && (!full || rd_acc);
    ovf_set = !flush_i && wr_en_i && !wr_acc;
    udf_set = !flush_i && rd_en_i && empty;

    wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, rd_acc};
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A fresh error in the same cycle as clear_err keeps the flag set.
    overflow_d  = (overflow_q  && !clear_err_i) || ovf_set;
    underflow_d = (underflow_q && !clear_err_i) || udf_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_acc_o       = wr_acc;
  assign wr_idx_o       = wr_ptr_q[AddrW-1:0];
  assign rd_idx_o       = rd_ptr_q[AddrW-1:0];
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AfLvl);
  assign almost_empty_o = (count_q <= AeLvl);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: register-array storage with a registered or
// show-ahead read path selected by MODE.
module fifo_param import fifo_pkg::*; #(
  parameter int unsigned DATA_W   = 15,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter fifo_mode_e  MODE     = FIFO_STD,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W   = fifo_cnt_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              clear_err,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("fifo_param: DATA_W must be >= 1");
  end

  logic              wr_acc;
  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0] mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .Depth   (DEPTH),
    .AfLevel (AF_LEVEL),
    .AeLevel (AE_LEVEL)
  ) u_ptr_ctrl (
    .clk_i          (clock),
    .rst_ni         (reset_n),
    .flush_i        (flush),
    .clear_err_i    (clear_err),
    .wr_en_i        (wr_en),
    .rd_en_i        (rd_en),
    .wr_acc_o       (wr_acc),
    .wr_idx_o       (wr_idx),
    .rd_idx_o       (rd_idx),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_fire;

    // Same read-accept condition the controller applies to its read pointer.
    assign rd_fire = rd_en && !empty && !flush;

    always_comb begin
      rd_valid_d = rd_fire;
      rd_data_d  = rd_fire ? mem_q[rd_idx] : rd_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= rd_valid_d;
        rd_data_q  <= rd_data_d;
      end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
  end else begin : g_fwft
    // Masked while empty so the unreset RAM never reaches the port.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_idx];
  end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench: drives one STD and one FWFT instance with shared stimulus
// and compares both against a queue-based model every cycle.
module tb_fifo_param;
  import fifo_pkg::*;

  localparam int unsigned DW    = 15;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0, clear_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;

  always #5 clock = ~clock;

  fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .MODE(FIFO_STD)) u_std (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clear_err(clear_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .MODE(FIFO_FWFT)) u_fwft (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clear_err(clear_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  // Model state
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_sv;
  logic [DW-1:0] m_sd;
  int            total = 0, bad = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_sv  = 1'b0;
    m_sd  = '0;
  endtask

  task automatic model_step(input bit w, input bit r, input bit f, input bit c,
                            input logic [DW-1:0] d);
    int n;
    bit racc, wacc;
    n = q.size();
    if (f) begin
      q.delete();
      m_sv = 1'b0;
      if (c) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
    end else begin
      racc  = r && (n > 0);
      wacc  = w && ((n < int'(DEPTH)) || racc);
      m_ovf = (m_ovf && !c) || (w && !wacc);
      m_udf = (m_udf && !c) || (r && (n == 0));
      m_sv  = racc;
      if (racc) m_sd = q.pop_front();
      if (wacc) q.push_back(d);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit f, input bit c,
                      input logic [DW-1:0] d);
    wr_en = w; rd_en = r; flush = f; clear_err = c; wr_data = d;
    @(posedge clock);
    model_step(w, r, f, c, d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_err = 1'b0;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    int n;
    if (chk_en) begin
      n = q.size();
      chk("std_count", 32'(s_count), 32'(n));
      chk("fwft_count", 32'(f_count), 32'(n));
      chk("count_bound", 32'(s_count <= CW'(DEPTH)), 32'd1);
      chk("std_full", 32'(s_full), 32'(n == int'(DEPTH)));
      chk("std_empty", 32'(s_empty), 32'(n == 0));
      chk("std_af", 32'(s_af), 32'(n >= int'(AF)));
      chk("std_ae", 32'(s_ae), 32'(n <= int'(AE)));
      chk("fwft_full", 32'(f_full), 32'(n == int'(DEPTH)));
      chk("fwft_empty", 32'(f_empty), 32'(n == 0));
      chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("std_udf", 32'(s_udf), 32'(m_udf));
      chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
      chk("fwft_udf", 32'(f_udf), 32'(m_udf));
      chk("std_rd_valid", 32'(s_rd_valid), 32'(m_sv));
      chk("std_rd_data", 32'(s_rd_data), 32'(m_sd));
      chk("fwft_rd_valid", 32'(f_rd_valid), 32'(n > 0));
      chk("fwft_rd_data", 32'(f_rd_data), (n > 0) ? 32'(q[0]) : 32'd0);
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_ae", 32'(s_ae), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_af", 32'(s_af), 32'd0);
    chk("rst_std_valid", 32'(s_rd_valid), 32'd0);
    chk("rst_std_data", 32'(s_rd_data), 32'd0);
    chk("rst_fwft_valid", 32'(f_rd_valid), 32'd0);
    chk("rst_fwft_data", 32'(f_rd_data), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Fill to full, then one dropped write
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0, DW'(i));
      if (i == 1) begin
        chk("fwft_first_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft_first_data", 32'(f_rd_data), 32'h0001);
      end
      if (i == 13) chk("af_at_13", 32'(s_af), 32'd0);
      if (i == 14) chk("af_at_14", 32'(s_af), 32'd1);
    end
    chk("full_after_16", 32'(s_full), 32'd1);
    chk("count_16", 32'(s_count), 32'd16);
    step(1, 0, 0, 0, 15'h0011);
    chk("ovf_17th", 32'(s_ovf), 32'd1);
    chk("count_17th", 32'(s_count), 32'd16);

    // Drain in STD order, then one refused read
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0, '0);
      chk("std_order", 32'(s_rd_data), 32'(i));
      chk("std_order_valid", 32'(s_rd_valid), 32'd1);
    end
    chk("empty_after_reads", 32'(s_empty), 32'd1);
    step(0, 1, 0, 0, '0);
    chk("udf_extra", 32'(s_udf), 32'd1);
    chk("valid_extra", 32'(s_rd_valid), 32'd0);
    step(0, 0, 0, 1, '0);
    chk("clr_ovf", 32'(s_ovf), 32'd0);
    chk("clr_udf", 32'(s_udf), 32'd0);

    // Simultaneous write/read while full, then while empty
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, DW'(i));
    step(1, 1, 0, 0, 15'h7FFF);
    chk("full_both_count", 32'(s_count), 32'd16);
    chk("full_both_data", 32'(s_rd_data), 32'h0001);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, '0);
    chk("last_out", 32'(s_rd_data), 32'h7FFF);
    step(1, 1, 0, 0, 15'h0123);
    chk("empty_both_count", 32'(s_count), 32'd1);
    chk("empty_both_udf", 32'(s_udf), 32'd1);

    // Show-ahead into empty
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    step(1, 0, 0, 0, 15'h0ABC);
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data", 32'(f_rd_data), 32'h0ABC);
    chk("std_no_valid", 32'(s_rd_valid), 32'd0);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, DW'($urandom));
    end

    // Flush with pending write and read
    for (int i = 0; i < int'(DEPTH) && q.size() > 0; i++) step(0, 1, 0, 0, '0);
    chk("drained", 32'(s_empty), 32'd1);
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, DW'(16'h0100 + i));
    chk("count_9", 32'(s_count), 32'd9);
    step(1, 1, 1, 0, 15'h5555);
    chk("flush_count", 32'(s_count), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    chk("flush_udf_kept", 32'(s_udf), 32'd1);
    chk("flush_ovf_kept", 32'(s_ovf), 32'd0);
    chk("flush_valid", 32'(s_rd_valid), 32'd0);
    step(0, 1, 0, 1, '0);
    chk("set_wins", 32'(s_udf), 32'd1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DW'(16'h0200 + i));
    step(1, 1, 0, 0, 15'h0300);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 15'h0301;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", 32'(s_count), 32'd0);
    chk("arst_empty", 32'(s_empty), 32'd1);
    chk("arst_ae", 32'(s_ae), 32'd1);
    chk("arst_udf", 32'(s_udf), 32'd0);
    chk("arst_std_valid", 32'(s_rd_valid), 32'd0);
    chk("arst_std_data", 32'(s_rd_data), 32'd0);
    chk("arst_fwft_valid", 32'(f_rd_valid), 32'd0);
    chk("arst_fwft_data", 32'(f_rd_data), 32'd0);
    @(posedge clock);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    reset_n = 1'b1;
    step(1, 0, 0, 0, 15'h0042);
    step(0, 1, 0, 0, '0);
    chk("post_rst_data", 32'(s_rd_data), 32'h0042);
    step(0, 0, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
